// File: rtl/rf_sequencer_pkg.sv
// rf_sequencer_pkg: shared op-codes, FunSel codes, register indices and FSM states
// Provides:
//   OP_*     command op-codes carried on cmd_op
//   FS_*     register file FunSel encodings
//   IDX_*    register indices, 0-3 = R1-R4, 4-7 = S1-S4
//   state_t  sequencer FSM states
//   uses_s4  true when a SWAP would clobber its own temporary
package rf_seq_pkg;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_INCN = 3'b110;
    localparam logic [2:0] OP_DECN = 3'b111;

    localparam logic [2:0] FS_DEC   = 3'b000;
    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LOAD  = 3'b010;
    localparam logic [2:0] FS_CLEAR = 3'b011;

    localparam logic [2:0] IDX_R1 = 3'd0;
    localparam logic [2:0] IDX_R2 = 3'd1;
    localparam logic [2:0] IDX_R3 = 3'd2;
    localparam logic [2:0] IDX_R4 = 3'd3;
    localparam logic [2:0] IDX_S1 = 3'd4;
    localparam logic [2:0] IDX_S2 = 3'd5;
    localparam logic [2:0] IDX_S3 = 3'd6;
    localparam logic [2:0] IDX_S4 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SW1,
        ST_SW2,
        ST_SW3,
        ST_REP
    } state_t;

    // S4 is the swap temporary, so a swap naming it cannot be sequenced
    function automatic logic uses_s4(input logic [2:0] a, input logic [2:0] b);
        return (a == IDX_S4) || (b == IDX_S4);
    endfunction

endpackage

// File: rtl/rf_sequencer_if.sv
// rf_sequencer_if: command handshake and register file control bundle
// Signals:
//   cmd_valid/cmd_ready   command handshake
//   cmd_op/dst/src/imm    command fields
//   rf_out_a              register file OutA read back
//   rf_i                  register file I data input
//   out_a_sel/out_b_sel   register file read selects
//   fun_sel               register file function select
//   reg_sel/scr_sel       one-hot write enables, bit3 = R1/S1 ... bit0 = R4/S4
//   done/error            one-cycle completion / rejection pulses
// Modports: master = command issuer plus register file, slave = sequencer
interface rf_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [2:0]        cmd_dst;
    logic [2:0]        cmd_src;
    logic [DATA_W-1:0] cmd_imm;
    logic [DATA_W-1:0] rf_out_a;
    logic [DATA_W-1:0] rf_i;
    logic [2:0]        out_a_sel;
    logic [2:0]        out_b_sel;
    logic [2:0]        fun_sel;
    logic [3:0]        reg_sel;
    logic [3:0]        scr_sel;
    logic              done;
    logic              error;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_out_a,
        input  cmd_ready, rf_i, out_a_sel, out_b_sel, fun_sel, reg_sel, scr_sel, done, error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_out_a,
        output cmd_ready, rf_i, out_a_sel, out_b_sel, fun_sel, reg_sel, scr_sel, done, error
    );

endinterface

// File: rtl/rf_sequencer_sel_decode.sv
// rf_sel_decode: register index plus write enable to one-hot RegSel/ScrSel
// Ports:
//   idx      3-bit register index, 0-3 = R1-R4, 4-7 = S1-S4
//   we       write enable
//   reg_sel  R1..R4 enables, bit3 = R1
//   scr_sel  S1..S4 enables, bit3 = S1
module rf_sel_decode (
    input  logic [2:0] idx,
    input  logic       we,
    output logic [3:0] reg_sel,
    output logic [3:0] scr_sel
);
    logic [3:0] oh;

    assign oh      = 4'b1000 >> idx[1:0];
    assign reg_sel = (we && !idx[2]) ? oh : 4'b0000;
    assign scr_sel = (we &&  idx[2]) ? oh : 4'b0000;

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: micro-op sequencer driving the 8-entry register file controls
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset; also masks all write enables
//   bus    rf_sequencer_if.slave: command handshake in, register file controls out
// Parameters:
//   DATA_W  register / immediate width
//   CNT_W   INCN/DECN repeat count width, taken from cmd_imm[CNT_W-1:0]
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_sequencer_if.slave  bus
);
    state_t            state, state_nxt;
    logic [2:0]        op, dst, src;
    logic [DATA_W-1:0] imm;
    logic [CNT_W-1:0]  cnt;
    logic              done_q, error_q, done_nxt, error_nxt;
    logic              we;
    logic [2:0]        wr_idx, a_sel, fs;
    logic [DATA_W-1:0] rf_i;
    logic              accept;
    logic              is_rep;

    assign accept = bus.cmd_valid && (state == ST_IDLE);
    assign is_rep = (bus.cmd_op == OP_INCN) || (bus.cmd_op == OP_DECN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_q  <= done_nxt;
            error_q <= error_nxt;
            if (accept) begin
                op  <= bus.cmd_op;
                dst <= bus.cmd_dst;
                src <= bus.cmd_src;
                imm <= bus.cmd_imm;
                cnt <= bus.cmd_imm[CNT_W-1:0];
            end else if (state == ST_REP) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        we        = 1'b0;
        wr_idx    = dst;
        a_sel     = IDX_R1;
        fs        = FS_LOAD;
        rf_i      = '0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    // Rejected swaps and zero-count repeats still spend one EXEC cycle
                    state_nxt = (bus.cmd_op == OP_SWAP && !uses_s4(bus.cmd_src, bus.cmd_dst)) ? ST_SW1 :
                                (is_rep && bus.cmd_imm[CNT_W-1:0] != '0) ? ST_REP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_IDLE;
                error_nxt = (op == OP_SWAP);
                done_nxt  = (op != OP_SWAP);
                we        = (op == OP_LDI) || (op == OP_CLR) || (op == OP_INC) ||
                            (op == OP_DEC) || (op == OP_MOV);
                fs        = (op == OP_CLR) ? FS_CLEAR :
                            (op == OP_INC) ? FS_INC :
                            (op == OP_DEC) ? FS_DEC : FS_LOAD;
                a_sel     = (op == OP_MOV) ? src : IDX_R1;
                rf_i      = (op == OP_LDI) ? imm :
                            (op == OP_MOV) ? bus.rf_out_a : '0;
            end
            ST_SW1: begin
                state_nxt = ST_SW2;
                we        = 1'b1;
                wr_idx    = IDX_S4;
                a_sel     = src;
                rf_i      = bus.rf_out_a;
            end
            ST_SW2: begin
                state_nxt = ST_SW3;
                we        = 1'b1;
                wr_idx    = src;
                a_sel     = dst;
                rf_i      = bus.rf_out_a;
            end
            ST_SW3: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                we        = 1'b1;
                wr_idx    = dst;
                a_sel     = IDX_S4;
                rf_i      = bus.rf_out_a;
            end
            ST_REP: begin
                we        = 1'b1;
                fs        = (op == OP_INCN) ? FS_INC : FS_DEC;
                // cnt counts remaining writes including this one
                state_nxt = (cnt == 1) ? ST_IDLE : ST_REP;
                done_nxt  = (cnt == 1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    rf_sel_decode u_sel (
        .idx     (wr_idx),
        .we      (we && rst_n),
        .reg_sel (bus.reg_sel),
        .scr_sel (bus.scr_sel)
    );

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rf_i      = rf_i;
    assign bus.out_a_sel = a_sel;
    assign bus.out_b_sel = (state == ST_IDLE) ? IDX_R1 : dst;
    assign bus.fun_sel   = fs;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: randomized self-checking bench with register file and reference model
module tb_rf_sequencer;
    import rf_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0;
    int   mis = 0;
    int   wr_cnt = 0;

    always #5 clk = ~clk;

    rf_sequencer_if bus ();

    rf_sequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] rf [8] = '{default: 32'h0};
    logic [31:0] ref_rf [8] = '{default: 32'h0};
    logic [7:0]  sel8;

    assign sel8         = {bus.reg_sel, bus.scr_sel};
    assign bus.rf_out_a = rf[bus.out_a_sel];

    // Register file model: index i is enabled by sel8[7-i]
    always @(posedge clk) begin
        if (|sel8) wr_cnt <= wr_cnt + 1;
        for (int i = 0; i < 8; i++) begin
            if (sel8[7-i]) begin
                case (bus.fun_sel)
                    FS_DEC:   rf[i] <= rf[i] - 32'd1;
                    FS_INC:   rf[i] <= rf[i] + 32'd1;
                    FS_LOAD:  rf[i] <= bus.rf_i;
                    FS_CLEAR: rf[i] <= 32'd0;
                    default:  rf[i] <= rf[i];
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                           input logic [31:0] imm);
        int w0, k, exp_w, n;
        logic exp_err;
        logic [31:0] t;
        exp_err = 1'b0;
        exp_w   = 1;
        n       = int'(imm[4:0]);
        case (op)
            OP_LDI:  ref_rf[dst] = imm;
            OP_CLR:  ref_rf[dst] = 32'd0;
            OP_INC:  ref_rf[dst] = ref_rf[dst] + 32'd1;
            OP_DEC:  ref_rf[dst] = ref_rf[dst] - 32'd1;
            OP_MOV:  ref_rf[dst] = ref_rf[src];
            OP_SWAP: begin
                if (src == 3'd7 || dst == 3'd7) begin
                    exp_err = 1'b1;
                    exp_w   = 0;
                end else begin
                    t           = ref_rf[src];
                    ref_rf[7]   = t;
                    ref_rf[src] = ref_rf[dst];
                    ref_rf[dst] = t;
                    exp_w       = 3;
                end
            end
            OP_INCN: begin
                ref_rf[dst] = ref_rf[dst] + 32'(n);
                exp_w       = n;
            end
            default: begin
                ref_rf[dst] = ref_rf[dst] - 32'(n);
                exp_w       = n;
            end
        endcase
        @(negedge clk);
        vec++;
        if (bus.cmd_ready !== 1'b1) begin
            mis++;
            $display("FAIL ready_idle op=%0d got %b want 1", op, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src   = src;
        bus.cmd_imm   = imm;
        w0 = wr_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 1;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && k < 80) begin
            vec++;
            if (bus.cmd_ready !== 1'b0 || $countones(sel8) > 1 || bus.out_b_sel !== dst) begin
                mis++;
                $display("FAIL busy_outputs op=%0d cyc=%0d ready=%b sel=%b outb=%0d want ready=0 sel<=1hot outb=%0d",
                         op, k, bus.cmd_ready, sel8, bus.out_b_sel, dst);
            end
            @(negedge clk);
            k++;
        end
        vec++;
        if (k != ((exp_w > 0) ? exp_w : 1) + 1) begin
            mis++;
            $display("FAIL latency op=%0d got %0d want %0d", op, k, ((exp_w > 0) ? exp_w : 1) + 1);
        end
        vec++;
        if (bus.done !== !exp_err || bus.error !== exp_err) begin
            mis++;
            $display("FAIL done_error op=%0d got done=%b err=%b want done=%b err=%b",
                     op, bus.done, bus.error, !exp_err, exp_err);
        end
        vec++;
        if (wr_cnt - w0 != exp_w) begin
            mis++;
            $display("FAIL write_cycles op=%0d got %0d want %0d", op, wr_cnt - w0, exp_w);
        end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (rf[i] !== ref_rf[i]) begin
                mis++;
                $display("FAIL reg%0d op=%0d got %h want %h", i, op, rf[i], ref_rf[i]);
            end
        end
    endtask

    task automatic test_reset();
        int w0;
        repeat (2) @(negedge clk);
        vec++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 || sel8 !== 8'h0) begin
            mis++;
            $display("FAIL reset_state got ready=%b done=%b err=%b sel=%b want 1 0 0 0",
                     bus.cmd_ready, bus.done, bus.error, sel8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_INCN;
        bus.cmd_dst   = IDX_R1;
        bus.cmd_src   = IDX_R1;
        bus.cmd_imm   = 32'd10;
        w0 = wr_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        ref_rf[0] = ref_rf[0] + 32'd2;
        repeat (2) begin
            #1;
            vec++;
            if (sel8 !== 8'h0) begin
                mis++;
                $display("FAIL reset_enables got %b want 00000000", sel8);
            end
            @(negedge clk);
            vec++;
            if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
                mis++;
                $display("FAIL reset_abort got ready=%b done=%b want 1 0", bus.cmd_ready, bus.done);
            end
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vec++;
            if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                mis++;
                $display("FAIL post_reset got done=%b ready=%b want 0 1", bus.done, bus.cmd_ready);
            end
        end
        vec++;
        if (wr_cnt - w0 != 2 || rf[0] !== ref_rf[0]) begin
            mis++;
            $display("FAIL reset_writes got %0d writes r1=%h want 2 writes r1=%h", wr_cnt - w0, rf[0], ref_rf[0]);
        end
    endtask

    task automatic test_ldi_mov();
        run_cmd(OP_LDI, IDX_R3, IDX_R1, 32'hDEADBEEF);
        run_cmd(OP_MOV, IDX_S2, IDX_R3, 32'h0);
        run_cmd(OP_CLR, IDX_S2, IDX_R1, 32'h0);
        run_cmd(OP_DEC, IDX_S2, IDX_R1, 32'h0);
    endtask

    task automatic test_swap();
        run_cmd(OP_LDI, IDX_R1, IDX_R1, 32'h11);
        run_cmd(OP_LDI, IDX_R2, IDX_R1, 32'h22);
        run_cmd(OP_SWAP, IDX_R2, IDX_R1, 32'h0);
        run_cmd(OP_SWAP, IDX_S1, IDX_S1, 32'h0);
        run_cmd(OP_SWAP, IDX_R1, IDX_S4, 32'h0);
        run_cmd(OP_SWAP, IDX_S4, IDX_R2, 32'h0);
    endtask

    task automatic test_incn();
        run_cmd(OP_LDI, IDX_R4, IDX_R1, 32'hFFFFFFFE);
        run_cmd(OP_INCN, IDX_R4, IDX_R1, 32'd3);
        run_cmd(OP_DECN, IDX_R4, IDX_R1, 32'd0);
        run_cmd(OP_DECN, IDX_S1, IDX_R1, 32'hFFFFFFFF);
        run_cmd(OP_INCN, IDX_S3, IDX_R1, 32'h00000120);
    endtask

    task automatic test_back_to_back();
        int acc, cyc, k;
        acc = 0;
        cyc = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_INC;
        bus.cmd_dst   = IDX_R1;
        bus.cmd_src   = IDX_R1;
        bus.cmd_imm   = 32'h0;
        while (acc < 3 && cyc < 40) begin
            if (bus.cmd_ready === 1'b1) begin
                acc++;
                if (acc > 1) begin
                    vec++;
                    if (bus.done !== 1'b1) begin
                        mis++;
                        $display("FAIL b2b_accept_on_done got done=%b want 1", bus.done);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        vec++;
        if (cyc != 5) begin
            mis++;
            $display("FAIL b2b_cycles got %0d want 5", cyc);
        end
        k = 0;
        while (bus.done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        ref_rf[0] = ref_rf[0] + 32'd3;
        vec++;
        if (rf[0] !== ref_rf[0]) begin
            mis++;
            $display("FAIL b2b_r1 got %h want %h", rf[0], ref_rf[0]);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 40; j++) begin
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_dst   = 3'd0;
        bus.cmd_src   = 3'd0;
        bus.cmd_imm   = 32'h0;
        test_reset();
        test_ldi_mov();
        test_swap();
        test_incn();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
Name: rf_sequencer

Overview:
- Micro-operation sequencer that drives the 8-entry register file's control inputs (R1-R4, S1-S4) and its I data input.
- Accepts one register-transfer command at a time over a valid/ready handshake and sequences it over one or more clock cycles.
- Reads the register file's OutA back for move/swap data.
- Sits directly upstream of the register file; the instruction decoder or testbench issues commands to it.

Parameters:
- DATA_W, 32, width of register data and the immediate.
- CNT_W, 5, width of the repeat count for INCN/DECN (taken from CmdImm[CNT_W-1:0]).

Ports:
- Clock  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low reset
- CmdValid  input  1  command present
- CmdReady  output  1  sequencer can accept a command
- CmdOp  input  3  000 LDI, 001 CLR, 010 INC, 011 DEC, 100 MOV, 101 SWAP, 110 INCN, 111 DECN
- CmdDst  input  3  destination index: 0-3 = R1-R4, 4-7 = S1-S4
- CmdSrc  input  3  source index, same encoding
- CmdImm  input  DATA_W  immediate for LDI; repeat count for INCN/DECN
- RfOutA  input  DATA_W  register file OutA
- RfI  output  DATA_W  register file I input
- OutASel  output  3  register file OutASel
- OutBSel  output  3  register file OutBSel
- FunSel  output  3  register file FunSel
- RegSel  output  4  register file RegSel; bit3 = R1 … bit0 = R4; active high
- ScrSel  output  4  register file ScrSel; bit3 = S1 … bit0 = S4; active high
- Done  output  1  one-cycle pulse: command completed
- Error  output  1  one-cycle pulse: command rejected

Behaviour:
- One clock (Clock); reset is synchronous and active-low (Reset).
- Reset low at a rising edge sets:
  - state IDLE, CmdReady=1, Done=0, Error=0, count 0.
  - RegSel and ScrSel are forced to 0 combinationally while Reset is low, so no register write happens in reset cycles.
  - Reset mid-operation aborts the command with no further writes and no Done.
- FunSel encodings used: DEC=000, INC=001, LOAD=010, CLEAR=011.
- Handshake and command capture:
  - CmdReady=1 only in IDLE.
  - Acceptance occurs on an edge where CmdValid & CmdReady; the command fields are latched on that edge.
- Control outputs are a combinational decode of state and latched command, active in the execute cycle; the register file writes on the edge ending that cycle.
- Idle outputs: RegSel=ScrSel=0, FunSel=LOAD, OutASel=OutBSel=0, RfI=0.
- States: IDLE, EXEC, SW1, SW2, SW3, REP.
- IDLE -> EXEC for LDI/CLR/INC/DEC/MOV; EXEC lasts 1 cycle, then IDLE with Done=1 in the next cycle.
  - LDI: RfI=Imm, FunSel=LOAD, enable Dst.
  - CLR: FunSel=CLEAR, enable Dst.
  - INC: FunSel=INC, enable Dst.
  - DEC: FunSel=DEC, enable Dst.
  - MOV: OutASel=Src, RfI=RfOutA, FunSel=LOAD, enable Dst.
- SWAP (3 write cycles), each step using OutASel=source, RfI=RfOutA, FunSel=LOAD:
  - SW1: S4 <- Src.
  - SW2: Src <- Dst.
  - SW3: Dst <- S4.
  - Then IDLE, Done.
  - Src==Dst: still 3 cycles, value unchanged.
  - Src==7 or Dst==7 (S4 is the temporary): no writes, one EXEC cycle, then IDLE with Error=1 and Done=0.
- INCN/DECN:
  - On accept, count <- CmdImm[CNT_W-1:0].
  - REP applies INC/DEC to Dst once per cycle, decrementing count; leave after the final write, then Done.
  - Count 0: one EXEC cycle with no enables, then Done.
  - Count 31: 31 cycles; the register value wraps modulo 2^32, no saturation.
- Enable decode is one-hot: exactly one bit across RegSel/ScrSel in any write cycle.
- OutBSel=Dst in non-IDLE states for downstream observation.
- Done and Error are registered, never both high.
- A new command may be accepted the cycle Done is high.
- CmdValid held while busy is ignored until CmdReady.

Decomposition:
- Package rf_seq_pkg holds:
  - op-code constants (OP_LDI … OP_DECN).
  - FunSel constants (FS_DEC, FS_INC, FS_LOAD, FS_CLEAR).
  - state enum.
  - register index constants (IDX_R1 … IDX_S4).
- One sub-module, rf_sel_decode: 3-bit index + write enable -> RegSel/ScrSel one-hot.
- FSM, counter and output decode live in rf_sequencer.

Test Plan:
- Reset low 2 cycles during an INCN with count 10 -> all enables 0 during reset; state IDLE, CmdReady=1, no Done.
- LDI Dst=2, Imm=0xDEADBEEF; then MOV Src=2, Dst=5 -> R3=0xDEADBEEF, then S2=0xDEADBEEF. Each command: exactly one enable cycle, Done one cycle after.
- R1=0x11, R2=0x22, SWAP Src=0, Dst=1 -> R1=0x22, R2=0x11, S4=0x11; 3 write cycles; CmdReady low for 3 cycles.
- SWAP Src=7, Dst=0 -> no enables asserted, Error pulse, Done=0, R1 and S4 unchanged.
- LDI R4=0xFFFFFFFE, INCN Dst=3, Imm=3 -> 3 INC cycles, R4=0x00000001 (wrap). Then DECN with Imm=0 -> no writes, Done after 1 cycle.
- CmdValid held high across back-to-back INC R1 x3 -> accepted only when CmdReady=1; R1 increments by exactly 3.
